// File: rtl/pipe_hazard_if.sv
// Hazard-status inputs and pipeline-register controls exchanged between the
// pipeline datapath and its sequencing controller.
interface pipe_hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [4:0]       ex_rt;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;

    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
               branch_taken, dmem_req, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
               branch_taken, dmem_req, dmem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: load-use stalls, branch flushes, and bounded
// whole-pipeline freezes for slow data-memory accesses, with saturating counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_hazard_if.slave bus
);
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    localparam logic [7:0]       TIMEOUT_C = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

    state_t           state_r;
    logic [7:0]       wait_cnt_r;
    logic             mem_err_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    logic mem_pending_s;
    logic freeze_s;
    logic timeout_s;
    logic load_use_s;
    logic stall_inc_s;
    logic flush_inc_s;
    logic [6:0] ctrl_s;

    // Hazard detection terms.
    always_comb begin
        mem_pending_s = bus.dmem_req & ~bus.dmem_ready;
        freeze_s      = mem_pending_s & (wait_cnt_r != TIMEOUT_C);
        timeout_s     = mem_pending_s & (wait_cnt_r == TIMEOUT_C);
        load_use_s    = bus.ex_memread & (bus.ex_rt != 5'd0) &
                        ((bus.ex_rt == bus.id_rs) |
                         (bus.id_uses_rt & (bus.ex_rt == bus.id_rt)));
        stall_inc_s   = freeze_s | (load_use_s & ~bus.branch_taken);
        flush_inc_s   = bus.branch_taken & ~freeze_s;
    end

    // Priority-ordered control word {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}.
    // A timed-out access is not a freeze, so it falls through to the lower cases.
    always_comb begin
        ctrl_s = 7'b0000000;
        if (!rst_n) begin
            ctrl_s = 7'b0000000;
        end else if (freeze_s) begin
            ctrl_s = 7'b0000000;
        end else if (bus.branch_taken) begin
            ctrl_s = 7'b1111111;
        end else if (load_use_s) begin
            ctrl_s = 7'b0011101;
        end else begin
            ctrl_s = 7'b1111100;
        end
    end

    assign bus.pc_en       = ctrl_s[6];
    assign bus.if_id_en    = ctrl_s[5];
    assign bus.id_ex_en    = ctrl_s[4];
    assign bus.ex_mem_en   = ctrl_s[3];
    assign bus.mem_wb_en   = ctrl_s[2];
    assign bus.if_id_flush = ctrl_s[1];
    assign bus.id_ex_flush = ctrl_s[0];
    assign bus.mem_err     = mem_err_r;
    assign bus.stall_cnt   = stall_cnt_r;
    assign bus.flush_cnt   = flush_cnt_r;

    // Memory-wait state machine, sticky timeout flag and saturating counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= RUN;
            wait_cnt_r  <= 8'd0;
            mem_err_r   <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (freeze_s) begin
                        state_r    <= MEMWAIT;
                        wait_cnt_r <= 8'd1;
                    end else begin
                        state_r    <= RUN;
                        wait_cnt_r <= 8'd0;
                    end
                end
                MEMWAIT: begin
                    if (freeze_s) begin
                        state_r    <= MEMWAIT;
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end else begin
                        state_r    <= RUN;
                        wait_cnt_r <= 8'd0;
                    end
                end
                default: begin
                    state_r    <= RUN;
                    wait_cnt_r <= 8'd0;
                end
            endcase

            if (timeout_s) begin
                mem_err_r <= 1'b1;
            end else begin
                mem_err_r <= mem_err_r;
            end

            if (stall_inc_s && (stall_cnt_r != CNT_MAX_C)) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end

            if (flush_inc_s && (flush_cnt_r != CNT_MAX_C)) begin
                flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT = 4 and 4-bit counters.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 4;

    localparam logic [6:0] C_OFF  = 7'b0000000;
    localparam logic [6:0] C_RUN  = 7'b1111100;
    localparam logic [6:0] C_BR   = 7'b1111111;
    localparam logic [6:0] C_LU   = 7'b0011101;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    pipe_hazard_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [6:0] ctrl;
    assign ctrl = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
                   bus.mem_wb_en, bus.if_id_flush, bus.id_ex_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.id_rs        = 5'd0;
        bus.id_rt        = 5'd0;
        bus.id_uses_rt   = 1'b0;
        bus.ex_memread   = 1'b0;
        bus.ex_rt        = 5'd0;
        bus.branch_taken = 1'b0;
        bus.dmem_req     = 1'b0;
        bus.dmem_ready   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.branch_taken = 1'b1;
        bus.ex_memread = 1'b1; bus.ex_rt = 5'd3; bus.id_rs = 5'd3;
        #1;
        total_cnt++;
        if (ctrl !== C_OFF) $display("FAIL reset_ctrl: got %b want %b", ctrl, C_OFF);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus.mem_err, bus.stall_cnt, bus.flush_cnt} !== 9'd0)
            $display("FAIL reset_state: got err=%b stall=%0d flush=%0d want 0/0/0",
                     bus.mem_err, bus.stall_cnt, bus.flush_cnt);
        else pass_cnt++;
        idle_inputs();
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (ctrl !== C_RUN) $display("FAIL reset_release: got %b want %b", ctrl, C_RUN);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        do_reset();
        bus.ex_memread = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5;
        #1;
        total_cnt++;
        if (ctrl !== C_LU) $display("FAIL lu_rs_ctrl: got %b want %b", ctrl, C_LU);
        else pass_cnt++;
        tick();
        idle_inputs();
        #1;
        total_cnt++;
        if (bus.stall_cnt !== 4'd1 || ctrl !== C_RUN)
            $display("FAIL lu_rs_after: got stall=%0d ctrl=%b want 1 %b", bus.stall_cnt, ctrl, C_RUN);
        else pass_cnt++;
        bus.ex_memread = 1'b1; bus.ex_rt = 5'd9; bus.id_rt = 5'd9;
        bus.id_uses_rt = 1'b1; bus.id_rs = 5'd3;
        #1;
        total_cnt++;
        if (ctrl !== C_LU) $display("FAIL lu_rt_ctrl: got %b want %b", ctrl, C_LU);
        else pass_cnt++;
        tick();
        idle_inputs();
        total_cnt++;
        if (bus.stall_cnt !== 4'd2) $display("FAIL lu_rt_cnt: got %0d want 2", bus.stall_cnt);
        else pass_cnt++;
    endtask

    task automatic test_no_stall();
        do_reset();
        bus.ex_memread = 1'b1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0;
        bus.id_uses_rt = 1'b1; bus.id_rt = 5'd0;
        #1;
        total_cnt++;
        if (ctrl !== C_RUN) $display("FAIL r0_ctrl: got %b want %b", ctrl, C_RUN);
        else pass_cnt++;
        tick();
        bus.ex_rt = 5'd7; bus.id_rt = 5'd7; bus.id_uses_rt = 1'b0; bus.id_rs = 5'd1;
        #1;
        total_cnt++;
        if (ctrl !== C_RUN) $display("FAIL unused_rt_ctrl: got %b want %b", ctrl, C_RUN);
        else pass_cnt++;
        tick();
        idle_inputs();
        total_cnt++;
        if (bus.stall_cnt !== 4'd0) $display("FAIL no_stall_cnt: got %0d want 0", bus.stall_cnt);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        do_reset();
        bus.ex_memread = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5;
        bus.branch_taken = 1'b1;
        #1;
        total_cnt++;
        if (ctrl !== C_BR) $display("FAIL br_lu_ctrl: got %b want %b", ctrl, C_BR);
        else pass_cnt++;
        tick();
        idle_inputs();
        total_cnt++;
        if (bus.flush_cnt !== 4'd1 || bus.stall_cnt !== 4'd0)
            $display("FAIL br_lu_cnt: got flush=%0d stall=%0d want 1 0", bus.flush_cnt, bus.stall_cnt);
        else pass_cnt++;
        bus.branch_taken = 1'b1;
        tick();
        idle_inputs();
        total_cnt++;
        if (bus.flush_cnt !== 4'd2) $display("FAIL br_back_to_back: got %0d want 2", bus.flush_cnt);
        else pass_cnt++;
    endtask

    task automatic test_mem_wait();
        do_reset();
        bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0; bus.branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if (ctrl !== C_OFF) $display("FAIL mw_freeze%0d: got %b want %b", i, ctrl, C_OFF);
            else pass_cnt++;
            tick();
        end
        bus.dmem_ready = 1'b1;
        #1;
        total_cnt++;
        if (ctrl !== C_BR) $display("FAIL mw_release: got %b want %b", ctrl, C_BR);
        else pass_cnt++;
        tick();
        idle_inputs();
        #1;
        total_cnt++;
        if (bus.stall_cnt !== 4'd3 || bus.flush_cnt !== 4'd1 || bus.mem_err !== 1'b0)
            $display("FAIL mw_status: got stall=%0d flush=%0d err=%b want 3 1 0",
                     bus.stall_cnt, bus.flush_cnt, bus.mem_err);
        else pass_cnt++;
        total_cnt++;
        if (ctrl !== C_RUN) $display("FAIL mw_run: got %b want %b", ctrl, C_RUN);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        do_reset();
        bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++;
            if (ctrl !== C_OFF || bus.mem_err !== 1'b0)
                $display("FAIL to_freeze%0d: got ctrl=%b err=%b want %b 0", i, ctrl, bus.mem_err, C_OFF);
            else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++;
        if (ctrl !== C_RUN || bus.mem_err !== 1'b0)
            $display("FAIL to_fifth: got ctrl=%b err=%b want %b 0", ctrl, bus.mem_err, C_RUN);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.mem_err !== 1'b1 || bus.stall_cnt !== 4'd4)
            $display("FAIL to_err: got err=%b stall=%0d want 1 4", bus.mem_err, bus.stall_cnt);
        else pass_cnt++;
        idle_inputs();
        for (int i = 0; i < 3; i++) tick();
        total_cnt++;
        if (bus.mem_err !== 1'b1) $display("FAIL to_sticky: got %b want 1", bus.mem_err);
        else pass_cnt++;
        do_reset();
        total_cnt++;
        if (bus.mem_err !== 1'b0) $display("FAIL to_clear: got %b want 0", bus.mem_err);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_freeze();
        do_reset();
        bus.branch_taken = 1'b1;
        tick();
        bus.branch_taken = 1'b0;
        bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (ctrl !== C_OFF) $display("FAIL rf_ctrl: got %b want %b", ctrl, C_OFF);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        total_cnt++;
        if ({bus.mem_err, bus.stall_cnt, bus.flush_cnt} !== 9'd0)
            $display("FAIL rf_state: got err=%b stall=%0d flush=%0d want 0/0/0",
                     bus.mem_err, bus.stall_cnt, bus.flush_cnt);
        else pass_cnt++;
        // Access still pending: a fresh full-length freeze proves the wait count restarted.
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++;
            if (ctrl !== C_OFF) $display("FAIL rf_refreeze%0d: got %b want %b", i, ctrl, C_OFF);
            else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++;
        if (ctrl !== C_RUN) $display("FAIL rf_timeout: got %b want %b", ctrl, C_RUN);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        bus.ex_memread = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5;
        for (int i = 0; i < 15; i++) tick();
        total_cnt++;
        if (bus.stall_cnt !== 4'd15) $display("FAIL sat_reach: got %0d want 15", bus.stall_cnt);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) tick();
        total_cnt++;
        if (bus.stall_cnt !== 4'd15) $display("FAIL sat_stall: got %0d want 15", bus.stall_cnt);
        else pass_cnt++;
        idle_inputs();
        bus.branch_taken = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        idle_inputs();
        total_cnt++;
        if (bus.flush_cnt !== 4'd15 || bus.stall_cnt !== 4'd15)
            $display("FAIL sat_flush: got flush=%0d stall=%0d want 15 15", bus.flush_cnt, bus.stall_cnt);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        idle_inputs();
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_in_freeze();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central sequencing controller for the five-stage pipeline. It drives the load enables and bubble-insert (flush) controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazards:
- load-use data hazards, by stalling the front end;
- taken branches, by flushing wrong-path instructions;
- multi-cycle data-memory accesses, by freezing the whole pipeline with a bounded timeout.

It also keeps saturating performance counters for stalls and flushes.

## Interface
- `MEM_TIMEOUT`, default 15: maximum consecutive freeze cycles allowed for one data-memory access (legal range 1..255).
- `CNT_W`, default 16: width of the performance counters.

Clock and reset: one clock; reset is synchronous and active-low.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.

Hazard inputs:
- `id_rs`  in  5  rs field of the instruction in ID.
- `id_rt`  in  5  rt field of the instruction in ID.
- `id_uses_rt`  in  1  the instruction in ID reads rt as a source.
- `ex_memread`  in  1  the instruction in EX is a load.
- `ex_rt`  in  5  destination register of the load in EX.
- `branch_taken`  in  1  branch in EX resolved taken this cycle.
- `dmem_req`  in  1  MEM stage has a data-memory access this cycle.
- `dmem_ready`  in  1  data memory completes the access this cycle.

Pipeline controls:
- `pc_en`  out  1  PC load enable.
- `if_id_en`  out  1  IF/ID load enable.
- `id_ex_en`  out  1  ID/EX load enable.
- `ex_mem_en`  out  1  EX/MEM load enable.
- `mem_wb_en`  out  1  MEM/WB load enable.
- `if_id_flush`  out  1  load a NOP into IF/ID.
- `id_ex_flush`  out  1  load a NOP (all control bits 0) into ID/EX.

Status:
- `mem_err`  out  1  sticky: a memory access hit the timeout.
- `stall_cnt`  out  `CNT_W`  number of stall and freeze cycles, saturating.
- `flush_cnt`  out  `CNT_W`  number of branch flushes, saturating.

## Operation
- State machine has two states, RUN and MEMWAIT, plus an 8-bit `wait_cnt` of consecutive freeze cycles.
- `mem_pending = dmem_req & ~dmem_ready`.
- `freeze = mem_pending & (wait_cnt != MEM_TIMEOUT)`.
- `timeout = mem_pending & (wait_cnt == MEM_TIMEOUT)`.
- `load_use = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)))`.

Controls are combinational. The first matching case, in the priority order below, wins:
1. `rst_n == 0`: all five enables 0, both flushes 0.
2. `freeze`: all enables 0, both flushes 0, so every pipeline register holds.
3. `branch_taken`: all enables 1, `if_id_flush = 1`, `id_ex_flush = 1`. The branch takes priority over `load_use`, because the instruction in ID is wrong-path.
4. `load_use`: `pc_en = 0`, `if_id_en = 0`, `id_ex_flush = 1`. `id_ex_en`, `ex_mem_en` and `mem_wb_en` are 1. `if_id_flush = 0`.
5. Otherwise: all enables 1, both flushes 0.

`timeout` is not a freeze. Controls follow cases 3–5, so the access is treated as completed.

State transitions:
- RUN → MEMWAIT on `freeze`; `wait_cnt` becomes 1.
- MEMWAIT stays in MEMWAIT on `freeze`; `wait_cnt` increments.
- MEMWAIT → RUN when `mem_pending` is 0; `wait_cnt` becomes 0.
- On `timeout`: go to RUN, `wait_cnt` becomes 0, `mem_err` becomes 1.
- A single access therefore freezes for at most `MEM_TIMEOUT` cycles.

Counters:
- `stall_cnt` increments by 1 on each cycle with `freeze`, or with `load_use & ~branch_taken`.
- `flush_cnt` increments by 1 on each cycle with `branch_taken & ~freeze`.
- Both counters saturate at 2^`CNT_W` − 1 and never wrap.
- `mem_err` clears only on reset.

## Timing
- Control outputs have zero-cycle latency: they are combinational from the inputs and `wait_cnt`, so they apply at the same rising edge.
- Reset, sampled at the edge with `rst_n = 0`, sets: state RUN, `wait_cnt = 0`, `mem_err = 0`, `stall_cnt = 0`, `flush_cnt = 0`.
- While `rst_n = 0`, controls are forced per case 1.
- Reset asserted during MEMWAIT aborts the wait with no `mem_err`.
- A load-use stall lasts exactly 1 cycle: the next cycle the load has moved to MEM and `ex_memread` is 0.
- A `freeze` coinciding with `branch_taken` or `load_use` masks both; they are re-evaluated after the freeze ends, because the inputs are held.
- `ex_rt == 0` never stalls.

## Test plan
- Load-use: `ex_memread = 1`, `ex_rt = 5`, `id_rs = 5` for 1 cycle → that cycle `pc_en = 0`, `if_id_en = 0`, `id_ex_flush = 1`, `ex_mem_en = 1`; `stall_cnt` goes 0 → 1.
- Register-0 and unused-rt cases: `ex_rt = 0`, `id_rs = 0` → no stall. Separately, `ex_rt = 7`, `id_rt = 7`, `id_uses_rt = 0` → no stall.
- Branch over load-use: `branch_taken = 1` together with the load-use condition → all enables 1, both flushes 1; `flush_cnt` +1, `stall_cnt` unchanged.
- Memory wait: `dmem_req = 1`, `dmem_ready = 0` for 3 cycles, then `ready = 1` → all enables 0 for exactly 3 cycles, then all enables 1; `stall_cnt = 3`; `mem_err = 0`; state returns to RUN.
- Timeout: `MEM_TIMEOUT = 4`, `dmem_ready` held at 0 → 4 freeze cycles; on the 5th cycle enables are 1; `mem_err = 1` from the next edge and stays 1 until `rst_n = 0`.
- Reset and saturation: assert `rst_n = 0` during a freeze → after the edge `wait_cnt = 0`, both counters 0, state RUN. With `CNT_W = 4`, drive 20 load-use stalls → `stall_cnt` holds at 15.
